buffer_stream_reader: RTL and testbench
=======================================

// Module: buffer_stream_reader
// PURPOSE
//  Read-side initiator for the memory buffer's broadcast (mode 1) port. On a start command it
//  issues a run of row reads: m1_r_en plus a stepping m1_r_addr. Each returned N_PE-wide row
//  is captured into a small FIFO and streamed to the PE array / next stage over valid/ready.
//  In-flight reads are credit-limited so the FIFO never overflows. Sits between the layer
//  controller and the memory buffer.
// PARAMETERS
//  N_PE        `N_PE         number of PE lanes (banks) per row
//  WID_PE_BITS `WID_PE_BITS  bits per lane
//  ADDR_RAM    `ADDR_RAM     row address width
//  FIFO_DEPTH  4             output FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 synchronous, active-high reset
//  start        in   1                 one-cycle command pulse, sampled only in IDLE
//  base_addr    in   ADDR_RAM          first row address
//  row_count    in   ADDR_RAM+1        rows to read (0..2^ADDR_RAM)
//  stride       in   ADDR_RAM          address increment (present only with BUF_RD_STRIDE_EN)
//  busy         out  1                 command in progress
//  done         out  1                 one-cycle completion pulse
//  buf_mode     out  1                 mode select to memory buffer; 1 while busy
//  m1_r_en      out  1                 broadcast read enable
//  m1_r_addr    out  ADDR_RAM          broadcast read address
//  m1_output_bus in  WID_PE_BITS*N_PE  read data, valid the cycle after m1_r_en
//  out_valid    out  1                 row available
//  out_ready    in   1                 consumer accepts row
//  out_data     out  WID_PE_BITS*N_PE  row data, lane i at bits [i*WID_PE_BITS +: WID_PE_BITS]
//  out_last     out  1                 marks final row of the command
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; FIFO, in-flight and row counters cleared. rst mid-command
//    aborts it with no done pulse and discards returned data.
//  - FSM IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE: start latches base_addr/row_count(/stride). If row_count!=0, go to ISSUE.
//    If row_count==0, pulse done in T+1 with no reads and stay in IDLE.
//  - ISSUE: assert m1_r_en when remaining>0 AND fifo_count+inflight < FIFO_DEPTH.
//    Current-cycle pops are not counted. Address advances by the step after each issue and
//    wraps modulo 2^ADDR_RAM. After the last issue, go to DRAIN.
//  - DRAIN: wait until inflight==0 and the final row (out_last) handshakes. Then pulse done and
//    go to IDLE.
//  - Timing: start at T -> first m1_r_en/addr=base at T+1 -> m1_output_bus valid T+2
//    -> FIFO write end of T+2 -> out_valid T+3. With out_ready held 1: one row/cycle, no bubbles.
//  - Handshake: a row transfers when out_valid&out_ready. out_data/out_last hold stable while
//    out_valid&!out_ready. out_valid never drops without a transfer.
//  - out_last is tagged at issue time on the row whose remaining count was 1.
//  - busy is 1 from T+1 through the done cycle inclusive. buf_mode==busy.
//  - start while busy is ignored. FIFO write and pop in the same cycle are both legal.
//  - m1_r_addr holds its last value when m1_r_en==0.
// CONFIGURATION
//  BUF_RD_STRIDE_EN defined: stride port exists; step = latched stride (0 re-reads one row).
//  Undefined: no stride port; step fixed at 1.
// STRUCTURE
//  - Shared header (header.vh): N_PE, WID_PE_BITS, ADDR_RAM, plus FSM state encodings
//    BRD_IDLE/BRD_ISSUE/BRD_DRAIN.
//  - Sub-module stream_fifo: synchronous FIFO, width WID_PE_BITS*N_PE+1 (data+last),
//    depth FIFO_DEPTH. Provides count/full/empty; no read-latency bubble (show-ahead).
//  - Top holds FSM, address/remaining/inflight counters and credit check.
// TESTING
//  - base=5,count=4,ready=1 -> m1_r_addr 5,6,7,8 on T+1..T+4. out rows T+3..T+6, last on row 4.
//    done at T+7.
//  - count=0 -> no m1_r_en; done at T+1; out_valid stays 0; busy never 1.
//  - base=2^ADDR_RAM-2, count=4 -> addresses 2^ADDR_RAM-2, 2^ADDR_RAM-1, 0, 1 (wrap).
//  - count=16, out_ready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, then stall.
//    Releasing ready delivers all 16 rows in order with no loss or duplication.
//  - rst asserted mid-ISSUE -> next cycle all outputs 0. New start then runs cleanly.
//    start pulsed while busy -> ignored.
//  - BUF_RD_STRIDE_EN, base=0, stride=3, count=3 -> addresses 0,3,6.

Source files
------------

// File: rtl/buffer_stream_reader_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for buffer_stream_reader.
// The optional stride feature is selected with the BUF_RD_STRIDE_EN macro in the top file.
package buffer_stream_reader_pkg;

  localparam int N_PE        = 4;
  localparam int WID_PE_BITS = 8;
  localparam int ADDR_RAM    = 6;
  localparam int ROW_W       = N_PE * WID_PE_BITS;

  localparam int FIFO_DEPTH  = 4;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    BRD_IDLE  = 2'd0,
    BRD_ISSUE = 2'd1,
    BRD_DRAIN = 2'd2
  } brd_state_e;

  // One FIFO entry: a full row plus its end-of-command tag.
  typedef struct packed {
    logic             last;
    logic [ROW_W-1:0] data;
  } row_t;

endpackage

// File: rtl/buffer_stream_reader_stream_fifo.sv
// Show-ahead synchronous FIFO: rd_data presents the head entry combinationally, so a
// write followed by a pop costs no bubble. DEPTH must be a power of two.
module stream_fifo
  import buffer_stream_reader_pkg::*;
#(
  parameter int WIDTH = $bits(row_t),
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem[rptr_q];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count/empty decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/buffer_stream_reader.sv
// Broadcast-port row reader: issues credit-limited reads and streams rows out over valid/ready.
// Define BUF_RD_STRIDE_EN to add the stride port; otherwise the address step is fixed at 1.
module buffer_stream_reader
  import buffer_stream_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_RAM-1:0] base_addr,
  input  logic [ADDR_RAM:0]   row_count,
`ifdef BUF_RD_STRIDE_EN
  input  logic [ADDR_RAM-1:0] stride,
`endif
  output logic                busy,
  output logic                done,
  output logic                buf_mode,
  output logic                m1_r_en,
  output logic [ADDR_RAM-1:0] m1_r_addr,
  input  logic [ROW_W-1:0]    m1_output_bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_W-1:0]    out_data,
  output logic                out_last
);

  brd_state_e            state_q, state_d;
  logic [ADDR_RAM-1:0]   next_addr_q, next_addr_d;
  logic [ADDR_RAM-1:0]   hold_addr_q, hold_addr_d;
  logic [ADDR_RAM:0]     remaining_q, remaining_d;
  logic [FIFO_CNT_W-1:0] inflight_q, inflight_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  wr_last_q, wr_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_RAM-1:0]   step;

`ifdef BUF_RD_STRIDE_EN
  logic [ADDR_RAM-1:0]   stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = ADDR_RAM'(1);
`endif

  row_t                  fifo_wdata, fifo_rdata;
  logic                  fifo_empty, fifo_full;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   occupancy;
  logic                  credit_ok, issue, out_fire;

  // Rows already queued plus reads whose data has not landed yet; pops this cycle are ignored.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok = !fifo_full && (occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
  assign issue     = (state_q == BRD_ISSUE) && (remaining_q != '0) && credit_ok;

  assign m1_r_en   = issue;
  assign m1_r_addr = issue ? next_addr_q : hold_addr_q;
  assign busy      = busy_q;
  assign buf_mode  = busy_q;
  assign done      = done_q;

  assign fifo_wdata = {wr_last_q, m1_output_bus};
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? fifo_rdata.data : '0;
  assign out_last   = out_valid && fifo_rdata.last;
  assign out_fire   = out_valid && out_ready;

  stream_fifo #(
    .WIDTH ($bits(row_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_pend_q),
    .wr_data (fifo_wdata),
    .rd_en   (out_ready),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    hold_addr_d = hold_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wr_pend_d   = issue;
    wr_last_d   = issue && (remaining_q == (ADDR_RAM + 1)'(1));
`ifdef BUF_RD_STRIDE_EN
    stride_d    = stride_q;
`endif

    case (state_q)
      BRD_IDLE: begin
        // busy_q is still high in the done cycle, which keeps a back-to-back start out.
        if (start && !busy_q) begin
          next_addr_d = base_addr;
          remaining_d = row_count;
`ifdef BUF_RD_STRIDE_EN
          stride_d    = stride;
`endif
          if (row_count != '0) state_d = BRD_ISSUE;
          else                 done_d  = 1'b1;
        end
      end
      BRD_ISSUE: begin
        if (issue) begin
          hold_addr_d = next_addr_q;
          next_addr_d = next_addr_q + step;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_RAM + 1)'(1)) state_d = BRD_DRAIN;
        end
      end
      BRD_DRAIN: begin
        if ((inflight_q == '0) && out_fire && out_last) begin
          state_d = BRD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = BRD_IDLE;
    endcase

    case ({issue, wr_pend_q})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    busy_d = (state_d != BRD_IDLE) || (state_q == BRD_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BRD_IDLE;
      next_addr_q <= '0;
      hold_addr_q <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      wr_pend_q   <= 1'b0;
      wr_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BUF_RD_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      hold_addr_q <= hold_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      wr_pend_q   <= wr_pend_d;
      wr_last_q   <= wr_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BUF_RD_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Directed bench for buffer_stream_reader: a cycle table for the basic command plus
// hand-written sequences for zero count, wrap, backpressure, reset abort, restart and stride.
module tb_buffer_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  row_count;
  logic [5:0]  stride_v;
  logic        busy, done, buf_mode, m1_r_en;
  logic [5:0]  m1_r_addr;
  logic [31:0] m1_output_bus;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_bad = 0;

  buffer_stream_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .row_count     (row_count),
`ifdef BUF_RD_STRIDE_EN
    .stride        (stride_v),
`endif
    .busy          (busy),
    .done          (done),
    .buf_mode      (buf_mode),
    .m1_r_en       (m1_r_en),
    .m1_r_addr     (m1_r_addr),
    .m1_output_bus (m1_output_bus),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of row address: every lane differs.
  function automatic logic [31:0] row_of(input logic [5:0] a);
    return {2'b10, a, 2'b01, ~a, a, 2'b11, 8'h5A ^ {2'b00, a}};
  endfunction

  // Memory model: data for a read appears on the bus the cycle after m1_r_en.
  initial m1_output_bus = '0;
  always @(posedge clk) if (m1_r_en) m1_output_bus <= row_of(m1_r_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        en;
    logic [5:0]  addr;
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic e, input logic [5:0] a,
                              input logic v, input logic l, input logic [31:0] d,
                              input logic b, input logic dn);
    vec_t t;
    t.start = s; t.ready = r; t.en = e; t.addr = a; t.valid = v;
    t.last = l; t.data = d; t.busy = b; t.done = dn;
    return t;
  endfunction

  // Runs one command; stall = cycles of out_ready=0 at the start, restart_at = cycle of a
  // stray start pulse while busy (-1 for none).
  task automatic run_cmd(input logic [5:0] base, input logic [6:0] cnt, input logic [5:0] stp,
                         input int stall, input int restart_at, input string tag);
    logic [5:0]  addrs[$];
    logic [31:0] rows[$];
    logic        lasts[$];
    logic [5:0]  a;
    logic [5:0]  step;
    int          cyc;
    bit          got_done;
`ifdef BUF_RD_STRIDE_EN
    step = stp;
`else
    step = 6'd1;
`endif
    base_addr = base;
    row_count = cnt;
    stride_v  = stp;
    out_ready = (stall == 0);
    start     = 1'b1;
    cyc       = 0;
    got_done  = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      if (m1_r_en) addrs.push_back(m1_r_addr);
      if (out_valid && out_ready) begin
        rows.push_back(out_data);
        lasts.push_back(out_last);
      end
      if (done) got_done = 1'b1;
      if (stall > 0 && cyc == stall - 1) begin
        check({tag, "_stall_reads"}, addrs.size(), 4);
        check({tag, "_stall_valid"}, out_valid, 1'b1);
        check({tag, "_stall_data"}, out_data, row_of(base));
      end
      next_cycle();
      cyc++;
      start     = (cyc == restart_at);
      if (cyc == restart_at) begin
        base_addr = 6'd50;
        row_count = 7'd1;
      end
      out_ready = (cyc >= stall);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_n_reads"}, addrs.size(), cnt);
    check({tag, "_n_rows"}, rows.size(), cnt);
    a = base;
    for (int k = 0; k < int'(cnt); k++) begin
      if (k < addrs.size()) check({tag, "_addr"}, addrs[k], a);
      if (k < rows.size()) begin
        check({tag, "_row"}, rows[k], row_of(a));
        check({tag, "_last"}, lasts[k], (k == int'(cnt) - 1));
      end
      a = a + step;
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_en"}, m1_r_en, 1'b0);
    next_cycle();
  endtask

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    row_count = '0;
    stride_v  = 6'd1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic command: base=5, count=4, out_ready held high; entry i is cycle T+i.
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0,      1'b0, 1'b0);
    tbl[1] = mk(1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 32'd0,      1'b1, 1'b0);
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 6'd6, 1'b0, 1'b0, 32'd0,      1'b1, 1'b0);
    tbl[3] = mk(1'b0, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, row_of(5),  1'b1, 1'b0);
    tbl[4] = mk(1'b0, 1'b1, 1'b1, 6'd8, 1'b1, 1'b0, row_of(6),  1'b1, 1'b0);
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0, row_of(7),  1'b1, 1'b0);
    tbl[6] = mk(1'b0, 1'b1, 1'b0, 6'd8, 1'b1, 1'b1, row_of(8),  1'b1, 1'b0);
    tbl[7] = mk(1'b0, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 32'd0,      1'b1, 1'b1);
    tbl[8] = mk(1'b0, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 32'd0,      1'b0, 1'b0);

    base_addr = 6'd5;
    row_count = 7'd4;
    for (int i = 0; i < 9; i++) begin
      start     = tbl[i].start;
      out_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("t%0d_r_en", i),  m1_r_en,   tbl[i].en);
      check($sformatf("t%0d_addr", i),  m1_r_addr, tbl[i].addr);
      check($sformatf("t%0d_valid", i), out_valid, tbl[i].valid);
      check($sformatf("t%0d_last", i),  out_last,  tbl[i].last);
      check($sformatf("t%0d_data", i),  out_data,  tbl[i].data);
      check($sformatf("t%0d_busy", i),  busy,      tbl[i].busy);
      check($sformatf("t%0d_mode", i),  buf_mode,  tbl[i].busy);
      check($sformatf("t%0d_done", i),  done,      tbl[i].done);
      next_cycle();
    end
    start = 1'b0;

    // Zero-length command: done at T+1, no reads, never busy.
    base_addr = 6'd3;
    row_count = 7'd0;
    start     = 1'b1;
    @(negedge clk);
    check("zero_done_t0", done, 1'b0);
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("zero_en_t%0d", c),    m1_r_en,   1'b0);
      check($sformatf("zero_busy_t%0d", c),  busy,      1'b0);
      check($sformatf("zero_valid_t%0d", c), out_valid, 1'b0);
      check($sformatf("zero_done_t%0d", c),  done,      (c == 1));
      next_cycle();
    end

    run_cmd(6'd62, 7'd4,  6'd1, 0,  -1, "wrap");
    run_cmd(6'd10, 7'd16, 6'd1, 20, -1, "bp");
    run_cmd(6'd30, 7'd5,  6'd1, 0,  2,  "rebusy");

    // Reset in the middle of ISSUE aborts the command and discards returning data.
    base_addr = 6'd20;
    row_count = 7'd8;
    out_ready = 1'b1;
    start     = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_r_en",  m1_r_en,   1'b0);
    check("rst_addr",  m1_r_addr, 6'd0);
    check("rst_busy",  busy,      1'b0);
    check("rst_mode",  buf_mode,  1'b0);
    check("rst_done",  done,      1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data",  out_data,  32'd0);
    check("rst_last",  out_last,  1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("rst_quiet_t%0d", c), {m1_r_en, out_valid, done, busy}, 4'b0000);
    end
    next_cycle();
    run_cmd(6'd40, 7'd3, 6'd1, 0, -1, "post_rst");

`ifdef BUF_RD_STRIDE_EN
    run_cmd(6'd0, 7'd3, 6'd3, 0, -1, "stride");
    run_cmd(6'd9, 7'd2, 6'd0, 0, -1, "stride0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
